param_counter: RTL and testbench

//  Parametrised next-generation mode counter. Width and up-step are parameters; a sticky wrap

---
 rtl/param_counter.sv | 125 ++++++++++++
 tb/tb_param_counter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_counter.sv
// -----------------------------------------------------------------------------
// param_counter
//   A parametrised mode counter. It can count up by STEP, count down by 1,
//   count up by 1, or load a parallel value. It produces two single-cycle
//   pulses: rco marks a wrap or boundary crossing, and load follows an
//   accepted parallel load. wrap_cnt is a saturating count of rco events.
//
// Parameters
//   WIDTH   counter width in bits (>=2)
//   STEP    increment used in mode 00 (1..2**WIDTH-1)
//   WRAP_W  width of wrap_cnt (>=1)
//
// Configuration macro
//   COUNTER_SAT_EN  When defined, Q clamps at 2**WIDTH-1 (modes 00/10) and at
//                   0 (mode 01) instead of wrapping. rco still pulses on every
//                   attempted overflow or underflow.
//
// Ports
//   clk       in   1       rising-edge clock
//   reset     in   1       asynchronous, active-low reset
//   enable    in   1       count/load enable
//   mode      in   2       00 up by STEP, 01 down 1, 10 up 1, 11 load D
//   D         in   WIDTH   parallel load value
//   clr_wrap  in   1       synchronous clear of wrap_cnt
//   Q         out  WIDTH   counter value (registered)
//   rco       out  1       ripple-carry pulse (registered)
//   load      out  1       pulse after an accepted load (registered)
//   wrap_cnt  out  WRAP_W  saturating count of rco events (registered)
// -----------------------------------------------------------------------------
module param_counter #(
    parameter int WIDTH  = 4,
    parameter int STEP   = 3,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [WIDTH-1:0]  D,
    input  logic              clr_wrap,
    output logic [WIDTH-1:0]  Q,
    output logic              rco,
    output logic              load,
    output logic [WRAP_W-1:0] wrap_cnt
);

    localparam logic [WIDTH:0]   STEP_W   = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] Q_MAX    = {WIDTH{1'b1}};
    localparam logic [WRAP_W-1:0] WRAP_MAX = {WRAP_W{1'b1}};

    // The sums are one bit wider than Q. The top bit is the overflow flag.
    logic [WIDTH:0]       sum_step;
    logic [WIDTH:0]       sum_one;
    logic [WIDTH-1:0]     q_next;
    logic                 rco_next;
    logic                 load_next;
    logic [WRAP_W-1:0]    wrap_next;

    assign sum_step = {1'b0, Q} + STEP_W;
    assign sum_one  = {1'b0, Q} + (WIDTH+1)'(1);

    always_comb begin
        q_next    = Q;
        rco_next  = 1'b0;
        load_next = 1'b0;
        if (enable) begin
            case (mode)
                2'b00: begin
                    rco_next = sum_step[WIDTH];
`ifdef COUNTER_SAT_EN
                    q_next = sum_step[WIDTH] ? Q_MAX : sum_step[WIDTH-1:0];
`else
                    q_next = sum_step[WIDTH-1:0];
`endif
                end
                2'b01: begin
                    rco_next = (Q == '0);
`ifdef COUNTER_SAT_EN
                    q_next = (Q == '0) ? '0 : Q - WIDTH'(1);
`else
                    q_next = Q - WIDTH'(1);
`endif
                end
                2'b10: begin
                    rco_next = sum_one[WIDTH];
`ifdef COUNTER_SAT_EN
                    q_next = sum_one[WIDTH] ? Q_MAX : sum_one[WIDTH-1:0];
`else
                    q_next = sum_one[WIDTH-1:0];
`endif
                end
                2'b11: begin
                    q_next    = D;
                    load_next = 1'b1;
                end
                // An unknown mode holds Q. This only matters in simulation.
                default: q_next = Q;
            endcase
        end
    end

    // A clear takes priority over a wrap on the same edge, and that wrap is lost.
    always_comb begin
        wrap_next = wrap_cnt;
        if (clr_wrap)
            wrap_next = '0;
        else if (rco_next && (wrap_cnt != WRAP_MAX))
            wrap_next = wrap_cnt + WRAP_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Q        <= '0;
            rco      <= 1'b0;
            load     <= 1'b0;
            wrap_cnt <= '0;
        end else begin
            Q        <= q_next;
            rco      <= rco_next;
            load     <= load_next;
            wrap_cnt <= wrap_next;
        end
    end

endmodule

// File: tb/tb_param_counter.sv
// -----------------------------------------------------------------------------
// tb_param_counter
//   Self-checking bench for param_counter with WIDTH=4, STEP=3, WRAP_W=8.
//   An integer behavioural model predicts every edge. Its prediction is
//   pushed into exp_q when the stimulus is driven, then popped and compared
//   with {Q, rco, load, wrap_cnt} one cycle later.
// -----------------------------------------------------------------------------
module tb_param_counter;

    localparam int WIDTH  = 4;
    localparam int STEP   = 3;
    localparam int WRAP_W = 8;
    localparam int MAXV   = 15;
    localparam int WMAX   = 255;
`ifdef COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic              enable;
    logic [1:0]        mode;
    logic [WIDTH-1:0]  D;
    logic              clr_wrap;
    logic [WIDTH-1:0]  Q;
    logic              rco;
    logic              load;
    logic [WRAP_W-1:0] wrap_cnt;

    // Packed observation: {Q, rco, load, wrap_cnt}
    logic [13:0] exp_q[$];
    logic [13:0] got;
    logic [13:0] exp;

    int m_q;
    int m_w;
    int total;
    int bad;

    param_counter #(.WIDTH(WIDTH), .STEP(STEP), .WRAP_W(WRAP_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .mode     (mode),
        .D        (D),
        .clr_wrap (clr_wrap),
        .Q        (Q),
        .rco      (rco),
        .load     (load),
        .wrap_cnt (wrap_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, summary not reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model ----------------
    task automatic model_step(input logic en, input logic [1:0] md,
                              input logic [3:0] d, input logic clr);
        int  nq;
        logic r;
        logic l;
        r  = 1'b0;
        l  = 1'b0;
        nq = m_q;
        if (en) begin
            case (md)
                2'd0: begin
                    nq = m_q + STEP;
                    if (nq > MAXV) begin
                        r  = 1'b1;
                        nq = SAT ? MAXV : nq - (MAXV + 1);
                    end
                end
                2'd1: begin
                    if (m_q == 0) begin
                        r  = 1'b1;
                        nq = SAT ? 0 : MAXV;
                    end else begin
                        nq = m_q - 1;
                    end
                end
                2'd2: begin
                    nq = m_q + 1;
                    if (nq > MAXV) begin
                        r  = 1'b1;
                        nq = SAT ? MAXV : 0;
                    end
                end
                default: begin
                    nq = int'(d);
                    l  = 1'b1;
                end
            endcase
        end
        if (clr) m_w = 0;
        else if (r && m_w < WMAX) m_w = m_w + 1;
        m_q = nq;
        exp_q.push_back({m_q[3:0], r, l, m_w[7:0]});
    endtask

    // ---------------- driver ----------------
    // Inputs change 1 time unit after a rising edge. The outputs for that
    // edge are sampled 1 time unit after the next rising edge.
    task automatic cycle(input logic en, input logic [1:0] md,
                         input logic [3:0] d, input logic clr);
        enable   = en;
        mode     = md;
        D        = d;
        clr_wrap = clr;
        model_step(en, md, d, clr);
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        #2;
        total++;
        if ({Q, rco, load, wrap_cnt} !== 14'd0) begin
            bad++;
            $display("FAIL reset_initial got=%h exp=%h", {Q, rco, load, wrap_cnt}, 14'd0);
        end
        @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        // Count up to 6 in mode 10.
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 2'b10, 4'h0, 1'b0);
            got = {Q, rco, load, wrap_cnt};
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL count_up_%0d got=%h exp=%h", i, got, exp);
            end
        end
        total++;
        if (Q !== 4'h6) begin
            bad++;
            $display("FAIL count_to_6 got=%h exp=6", Q);
        end
        // Assert reset in the middle of the cycle. It must act before the next edge.
        #3;
        reset = 1'b0;
        #1;
        total++;
        if ({Q, rco, load, wrap_cnt} !== 14'd0) begin
            bad++;
            $display("FAIL reset_async got=%h exp=%h", {Q, rco, load, wrap_cnt}, 14'd0);
        end
        @(posedge clk);
        #1;
        total++;
        if ({Q, rco, load, wrap_cnt} !== 14'd0) begin
            bad++;
            $display("FAIL reset_hold got=%h exp=%h", {Q, rco, load, wrap_cnt}, 14'd0);
        end
        #3;
        reset = 1'b1;
        m_q = 0;
        m_w = 0;
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_load;
        cycle(1'b1, 2'b11, 4'hA, 1'b0);
        got = {Q, rco, load, wrap_cnt};
        exp = exp_q.pop_front();
        total++;
        if (got !== exp || Q !== 4'hA || load !== 1'b1) begin
            bad++;
            $display("FAIL load_A got=%h exp=%h", got, exp);
        end
        cycle(1'b1, 2'b10, 4'h0, 1'b0);
        got = {Q, rco, load, wrap_cnt};
        exp = exp_q.pop_front();
        total++;
        if (got !== exp || Q !== 4'hB || load !== 1'b0) begin
            bad++;
            $display("FAIL load_then_up got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 2'b11, 4'(i + 3), 1'b0);
            got = {Q, rco, load, wrap_cnt};
            exp = exp_q.pop_front();
            total++;
            if (got !== exp || load !== 1'b1) begin
                bad++;
                $display("FAIL back_to_back_load_%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_step_wrap;
        logic [7:0] w0;
        cycle(1'b1, 2'b11, 4'hE, 1'b0);
        void'(exp_q.pop_front());
        w0 = wrap_cnt;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 2'b00, 4'h0, 1'b0);
            got = {Q, rco, load, wrap_cnt};
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL step_wrap_%0d got=%h exp=%h", i, got, exp);
            end
            if (i == 0) begin
                total++;
                if (Q !== (SAT ? 4'hF : 4'h1) || rco !== 1'b1 || wrap_cnt !== w0 + 8'd1) begin
                    bad++;
                    $display("FAIL step_wrap_first got=Q%h rco%b w%h exp=Q%h rco1 w%h",
                             Q, rco, wrap_cnt, SAT ? 4'hF : 4'h1, w0 + 8'd1);
                end
            end
        end
    endtask

    task automatic test_down_wrap;
        cycle(1'b1, 2'b11, 4'h0, 1'b0);
        void'(exp_q.pop_front());
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 2'b01, 4'h0, 1'b0);
            got = {Q, rco, load, wrap_cnt};
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL down_wrap_%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_enable_hold;
        cycle(1'b1, 2'b11, 4'h7, 1'b0);
        void'(exp_q.pop_front());
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 2'b10, 4'h0, 1'b0);
            got = {Q, rco, load, wrap_cnt};
            exp = exp_q.pop_front();
            total++;
            if (got !== exp || Q !== 4'h7 || rco !== 1'b0 || load !== 1'b0) begin
                bad++;
                $display("FAIL enable_hold_%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_wrap_sat;
        int errs;
        errs = 0;
        cycle(1'b1, 2'b11, 4'h0, 1'b1);
        void'(exp_q.pop_front());
        for (int i = 0; i < 300 * 16; i++) begin
            cycle(1'b1, 2'b10, 4'h0, 1'b0);
            got = {Q, rco, load, wrap_cnt};
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                errs++;
                if (errs < 10) $display("FAIL wrap_run_%0d got=%h exp=%h", i, got, exp);
            end
        end
        total++;
        if (wrap_cnt !== 8'hFF) begin
            bad++;
            $display("FAIL wrap_saturate got=%h exp=ff", wrap_cnt);
        end
        cycle(1'b1, 2'b11, 4'hF, 1'b0);
        void'(exp_q.pop_front());
        cycle(1'b1, 2'b10, 4'h0, 1'b1);
        got = {Q, rco, load, wrap_cnt};
        exp = exp_q.pop_front();
        total++;
        if (got !== exp || wrap_cnt !== 8'h00 || rco !== 1'b1) begin
            bad++;
            $display("FAIL clr_on_wrap got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_random;
        logic [1:0] md;
        for (int i = 0; i < 400; i++) begin
            md = 2'($urandom_range(0, 3));
            cycle(1'($urandom_range(0, 3) != 0), md, 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 19) == 0));
            got = {Q, rco, load, wrap_cnt};
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL random_%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        total    = 0;
        bad      = 0;
        m_q      = 0;
        m_w      = 0;
        reset    = 1'b0;
        enable   = 1'b0;
        mode     = 2'b00;
        D        = '0;
        clr_wrap = 1'b0;
        test_reset();
        test_load();
        test_back_to_back();
        test_step_wrap();
        test_down_wrap();
        test_enable_hold();
        test_wrap_sat();
        test_random();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
